ejector: RTL and testbench

//  Ejection stage of the bufferless deflection router; counterpart of the injector.

---
 rtl/ejector_if.sv | 40 ++++
 rtl/ejector.sv | 130 +++++++++++++
 tb/tb_ejector.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ejector_if.sv
// Link-side bundle of the ejection stage: the four incoming slots, the four
// registered pass-through slots and the local-core drain port.
interface ejector_if #(
  parameter int unsigned FLIT_W   = 10,
  parameter int unsigned EJ_DEPTH = 4
);
  localparam int unsigned CW = $clog2(EJ_DEPTH) + 1;

  logic [FLIT_W-1:0] in_e;
  logic [FLIT_W-1:0] in_w;
  logic [FLIT_W-1:0] in_n;
  logic [FLIT_W-1:0] in_s;
  logic [3:0]        in_vld;

  logic [FLIT_W-1:0] out_e;
  logic [FLIT_W-1:0] out_w;
  logic [FLIT_W-1:0] out_n;
  logic [FLIT_W-1:0] out_s;
  logic [3:0]        out_vld;

  logic [FLIT_W-1:0] ej_flit;
  logic              ej_valid;
  logic              ej_ready;
  logic [CW-1:0]     ej_count;
  logic              eject_hit;

  // Ejector side: consumes link flits and the core's ready.
  modport slave (
    input  in_e, in_w, in_n, in_s, in_vld, ej_ready,
    output out_e, out_w, out_n, out_s, out_vld,
    output ej_flit, ej_valid, ej_count, eject_hit
  );

  // Environment side: drives link flits and the core's ready.
  modport master (
    output in_e, in_w, in_n, in_s, in_vld, ej_ready,
    input  out_e, out_w, out_n, out_s, out_vld,
    input  ej_flit, ej_valid, ej_count, eject_hit
  );
endinterface

// File: rtl/ejector.sv
// Ejection stage of a bufferless deflection router. At most one flit addressed
// to this node is pulled off the four links per cycle (round-robin among the
// candidates) into a small FIFO draining to the local core; every other flit
// is forwarded one cycle later, and the ejected slot is handed on as free.
module ejector #(
  parameter int unsigned FLIT_W     = 10,
  parameter logic [5:0]  LOCAL_ADDR = 6'd37,
  parameter int unsigned EJ_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  ejector_if.slave   bus
);
  localparam int unsigned AW = $clog2(EJ_DEPTH);
  localparam int unsigned CW = AW + 1;

  // Slot view of the links: 0=E, 1=W, 2=N, 3=S.
  logic [FLIT_W-1:0] in_flit [4];
  logic [3:0]        cand;

  // Round-robin selection.
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        scan_idx;
  logic [1:0]        win_idx;
  logic              win_found;
  logic [3:0]        win_mask;
  logic [FLIT_W-1:0] win_flit;

  // FIFO control.
  logic              ej_en;
  logic              push;
  logic              pop;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [FLIT_W-1:0] mem [EJ_DEPTH];

  // Pass-through registers.
  logic [FLIT_W-1:0] out_e_q, out_w_q, out_n_q, out_s_q;
  logic [3:0]        out_vld_q, out_vld_d;
  logic              eject_hit_q;

  assign in_flit[0] = bus.in_e;
  assign in_flit[1] = bus.in_w;
  assign in_flit[2] = bus.in_n;
  assign in_flit[3] = bus.in_s;

  // A slot is a candidate when it carries a valid flit destined for this node.
  always_comb begin
    cand = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cand[i] = bus.in_vld[i] && (in_flit[i][5:0] == LOCAL_ADDR);
    end
  end

  // Pick the first candidate at or after rr_q, wrapping around the four slots.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    scan_idx  = rr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_q + 2'(k);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Eject/pop decisions and next-state for pointers, count and pass-through valid.
  // Eligibility looks at the count before this cycle's pop, so a full FIFO
  // never accepts a flit even while the core is draining it.
  always_comb begin
    ej_en     = (count_q < CW'(EJ_DEPTH));
    push      = win_found && ej_en;
    pop       = (count_q != '0) && bus.ej_ready;
    win_mask  = push ? (4'b0001 << win_idx) : 4'b0000;
    win_flit  = in_flit[win_idx];
    out_vld_d = bus.in_vld & ~win_mask;
    rr_d      = push ? (win_idx + 2'd1) : rr_q;
    wr_ptr_d  = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
  end

  // Control and pass-through state; reset discards in-flight flits and FIFO contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_e_q     <= '0;
      out_w_q     <= '0;
      out_n_q     <= '0;
      out_s_q     <= '0;
      out_vld_q   <= 4'b0000;
      rr_q        <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      eject_hit_q <= 1'b0;
    end else begin
      out_e_q     <= bus.in_e;
      out_w_q     <= bus.in_w;
      out_n_q     <= bus.in_n;
      out_s_q     <= bus.in_s;
      out_vld_q   <= out_vld_d;
      rr_q        <= rr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      eject_hit_q <= push;
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= win_flit;
    end
  end

  assign bus.out_e     = out_e_q;
  assign bus.out_w     = out_w_q;
  assign bus.out_n     = out_n_q;
  assign bus.out_s     = out_s_q;
  assign bus.out_vld   = out_vld_q;
  assign bus.ej_flit   = mem[rd_ptr_q];
  assign bus.ej_valid  = (count_q != '0);
  assign bus.ej_count  = count_q;
  assign bus.eject_hit = eject_hit_q;

endmodule

// File: tb/tb_ejector.sv
// Directed bench for the ejector: a table of per-cycle vectors with
// hand-computed expectations, followed by reset and full-burst sequences.
module tb_ejector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ejector_if #(.FLIT_W(10), .EJ_DEPTH(4)) bus ();

  ejector #(.FLIT_W(10), .LOCAL_ADDR(6'd37), .EJ_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] vld;
    logic [9:0] e;
    logic [9:0] w;
    logic [9:0] n;
    logic [9:0] s;
    logic       rdy;
    logic [3:0] x_vld;
    logic       x_ev;
    logic [2:0] x_cnt;
    logic       x_hit;
    logic [9:0] x_flit;
  } vec_t;

  vec_t tbl [14];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [9:0] L(input int t);
    logic [3:0] tag;
    tag = 4'(t);
    return {tag, 6'd37};
  endfunction

  function automatic logic [9:0] N(input int t);
    logic [3:0] tag;
    tag = 4'(t);
    return {tag, 6'd12};
  endfunction

  function automatic vec_t mk(input logic [3:0] vld, input logic [9:0] e, input logic [9:0] w,
                              input logic [9:0] n, input logic [9:0] s, input logic rdy,
                              input logic [3:0] x_vld, input logic x_ev, input logic [2:0] x_cnt,
                              input logic x_hit, input logic [9:0] x_flit);
    vec_t v;
    v.vld = vld; v.e = e; v.w = w; v.n = n; v.s = s; v.rdy = rdy;
    v.x_vld = x_vld; v.x_ev = x_ev; v.x_cnt = x_cnt; v.x_hit = x_hit; v.x_flit = x_flit;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vld, input logic [9:0] e, input logic [9:0] w,
                       input logic [9:0] n, input logic [9:0] s, input logic rdy);
    bus.in_vld   = vld;
    bus.in_e     = e;
    bus.in_w     = w;
    bus.in_n     = n;
    bus.in_s     = s;
    bus.ej_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the registered outputs after one cycle of a given vector.
  task automatic check_vec(input string tag, input vec_t v);
    chk($sformatf("%s out_vld", tag), 32'(bus.out_vld), 32'(v.x_vld));
    chk($sformatf("%s ej_valid", tag), 32'(bus.ej_valid), 32'(v.x_ev));
    chk($sformatf("%s ej_count", tag), 32'(bus.ej_count), 32'(v.x_cnt));
    chk($sformatf("%s eject_hit", tag), 32'(bus.eject_hit), 32'(v.x_hit));
    if (v.x_ev) chk($sformatf("%s ej_flit", tag), 32'(bus.ej_flit), 32'(v.x_flit));
    if (v.x_vld[0]) chk($sformatf("%s out_e", tag), 32'(bus.out_e), 32'(v.e));
    if (v.x_vld[1]) chk($sformatf("%s out_w", tag), 32'(bus.out_w), 32'(v.w));
    if (v.x_vld[2]) chk($sformatf("%s out_n", tag), 32'(bus.out_n), 32'(v.n));
    if (v.x_vld[3]) chk($sformatf("%s out_s", tag), 32'(bus.out_s), 32'(v.s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;

    //            vld      e      w      n      s     rdy  x_vld  ev cnt hit flit
    tbl[0]  = mk(4'b0100, N(1),  N(2),  L(8),  N(3),  0, 4'b0000, 1, 1, 1, L(8));
    tbl[1]  = mk(4'b1111, N(4),  N(5),  N(6),  N(7),  0, 4'b1111, 1, 1, 0, L(8));
    tbl[2]  = mk(4'b0000, N(0),  N(0),  N(0),  N(0),  1, 4'b0000, 0, 0, 0, 10'd0);
    tbl[3]  = mk(4'b1111, L(1),  L(2),  L(3),  L(4),  0, 4'b0111, 1, 1, 1, L(4));
    tbl[4]  = mk(4'b1111, L(1),  L(2),  L(3),  L(4),  0, 4'b1110, 1, 2, 1, L(4));
    tbl[5]  = mk(4'b1000, L(12), N(10), N(11), L(5),  0, 4'b0000, 1, 3, 1, L(4));
    tbl[6]  = mk(4'b0011, L(6),  L(7),  N(13), N(14), 0, 4'b0010, 1, 4, 1, L(4));
    tbl[7]  = mk(4'b1111, L(1),  L(2),  L(3),  L(4),  0, 4'b1111, 1, 4, 0, L(4));
    tbl[8]  = mk(4'b0010, N(15), L(9),  N(0),  N(1),  1, 4'b0010, 1, 3, 0, L(1));
    tbl[9]  = mk(4'b0000, N(0),  N(0),  N(0),  N(0),  1, 4'b0000, 1, 2, 0, L(5));
    tbl[10] = mk(4'b1000, N(2),  N(3),  N(4),  L(10), 1, 4'b0000, 1, 2, 1, L(6));
    tbl[11] = mk(4'b0000, N(0),  N(0),  N(0),  N(0),  1, 4'b0000, 1, 1, 0, L(10));
    tbl[12] = mk(4'b0000, N(0),  N(0),  N(0),  N(0),  1, 4'b0000, 0, 0, 0, 10'd0);
    tbl[13] = mk(4'b0000, N(0),  N(0),  N(0),  N(0),  1, 4'b0000, 0, 0, 0, 10'd0);

    drive(4'b0000, '0, '0, '0, '0, 1'b0);

    // Reset state.
    #2;
    chk("reset out_vld", 32'(bus.out_vld), 32'd0);
    chk("reset ej_valid", 32'(bus.ej_valid), 32'd0);
    chk("reset ej_count", 32'(bus.ej_count), 32'd0);
    chk("reset eject_hit", 32'(bus.eject_hit), 32'd0);
    chk("reset out_n", 32'(bus.out_n), 32'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors; state carries from one row to the next.
    for (int i = 0; i < 14; i++) begin
      v = tbl[i];
      drive(v.vld, v.e, v.w, v.n, v.s, v.rdy);
      step();
      check_vec($sformatf("vec%0d", i), v);
    end

    // Build occupancy 3, then assert reset asynchronously mid-cycle.
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, L(i + 1), N(0), N(0), N(0), 1'b0);
      step();
      chk($sformatf("fill%0d ej_count", i), 32'(bus.ej_count), 32'(i + 1));
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ej_valid", 32'(bus.ej_valid), 32'd0);
    chk("async rst ej_count", 32'(bus.ej_count), 32'd0);
    chk("async rst out_vld", 32'(bus.out_vld), 32'd0);
    chk("async rst eject_hit", 32'(bus.eject_hit), 32'd0);
    chk("async rst out_e", 32'(bus.out_e), 32'd0);

    // All four slots local, core stalled: slots 0..3 eject in turn, then full.
    drive(4'b1111, L(11), L(12), L(13), L(14), 1'b0);
    @(posedge clk);
    #2;
    chk("held rst ej_count", 32'(bus.ej_count), 32'd0);
    chk("held rst out_vld", 32'(bus.out_vld), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("burst%0d out_vld", i), 32'(bus.out_vld), 32'(4'b1111 & ~(4'b0001 << i)));
      chk($sformatf("burst%0d eject_hit", i), 32'(bus.eject_hit), 32'd1);
      chk($sformatf("burst%0d ej_count", i), 32'(bus.ej_count), 32'(i + 1));
      chk($sformatf("burst%0d ej_flit", i), 32'(bus.ej_flit), 32'(L(11)));
    end
    step();
    chk("full out_vld", 32'(bus.out_vld), 32'hf);
    chk("full eject_hit", 32'(bus.eject_hit), 32'd0);
    chk("full ej_count", 32'(bus.ej_count), 32'd4);
    chk("full ej_flit stable", 32'(bus.ej_flit), 32'(L(11)));
    chk("full out_s", 32'(bus.out_s), 32'(L(14)));

    // Drain in order with no new traffic.
    drive(4'b0000, N(0), N(0), N(0), N(0), 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("drain%0d ej_count", i), 32'(bus.ej_count), 32'(3 - i));
      if (i < 3) chk($sformatf("drain%0d ej_flit", i), 32'(bus.ej_flit), 32'(L(12 + i)));
    end
    chk("drained ej_valid", 32'(bus.ej_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
